// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout is the borrow out of this bit.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit pair per clock, LSB first, result latched with a done pulse.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             bin_reg;
    logic [CW-1:0]    cnt_reg;
    logic             d_bit;
    logic             bout_bit;

    full_subtractor u_fs (
        .x    (a_reg[0]),
        .y    (b_reg[0]),
        .bin  (bin_reg),
        .d    (d_bit),
        .bout (bout_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            bin_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        bin_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_reg != CW'(WIDTH)) begin
                        res_reg <= {d_bit, res_reg[WIDTH-1:1]};
                        a_reg   <= {1'b0, a_reg[WIDTH-1:1]};
                        b_reg   <= {1'b0, b_reg[WIDTH-1:1]};
                        bin_reg <= bout_bit;
                        cnt_reg <= cnt_reg + CW'(1);
                    end else begin
                        // All bits processed: publish the result on this extra edge.
                        diff      <= res_reg;
                        borrow    <= bin_reg;
                        zero      <= (res_reg == '0);
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, random ops and reset/overlap corner cases.
module tb_serial_subtractor;

    localparam int W       = 8;
    localparam int LATENCY = W + 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
    } vec_t;

    res_t exp_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   done_count = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            res_t e;
            done_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got diff=%0h with no operation pending", diff);
            end else begin
                e = exp_q.pop_front();
                chk("diff",   32'(diff),   32'(e.diff));
                chk("borrow", 32'(borrow), 32'(e.borrow));
                chk("zero",   32'(zero),   32'(e.zero));
                $display("op result diff=%02h borrow=%0b zero=%0b (exp %02h %0b %0b)",
                         diff, borrow, zero, e.diff, e.borrow, e.zero);
            end
        end
    end

    // Called #1 after an edge while the DUT is idle; returns #1 after the DONE->IDLE edge.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input logic ez);
        int cycles;
        a = av;
        b = bv;
        start = 1'b1;
        exp_q.push_back('{diff: ed, borrow: eb, zero: ez});
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        cycles = 0;
        while (!done && cycles < 40) begin
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            cycles++;
        end
        chk("latency", 32'(cycles), 32'(LATENCY));
        @(posedge clk); #1;
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t tbl[10];
        logic [W-1:0] ra, rb;
        int cycles;
        int dc;

        tbl[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[2] = '{8'h77, 8'h77, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};
        tbl[4] = '{8'h0F, 8'hFF, 8'h10, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b0};
        tbl[6] = '{8'h01, 8'h00, 8'h01, 1'b0, 1'b0};
        tbl[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[8] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[9] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_done",   32'(done),   32'd0);
        chk("reset_diff",   32'(diff),   32'd0);
        chk("reset_borrow", 32'(borrow), 32'd0);
        chk("reset_zero",   32'(zero),   32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_start", 32'(busy), 32'd0);

        // Table entries run back-to-back: each start lands in the IDLE cycle right after DONE.
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].borrow, tbl[i].zero);
        end

        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, ra - rb, ra < rb, (ra == rb));
        end

        // A start held high during RUN must be ignored.
        dc = done_count;
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        exp_q.push_back('{diff: 8'h0F, borrow: 1'b0, zero: 1'b0});
        @(posedge clk); #1;
        a = 8'hFF;
        b = 8'h00;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        chk("overlap_latency", 32'(cycles), 32'(LATENCY));
        repeat (LATENCY + 4) @(posedge clk);
        #1;
        chk("overlap_one_done", 32'(done_count - dc), 32'd1);
        chk("overlap_diff_hold", 32'(diff), 32'h0F);
        chk("overlap_idle", 32'(busy), 32'd0);

        // Reset at the 4th RUN edge aborts the operation without a done pulse.
        dc = done_count;
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        repeat (LATENCY + 4) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_count - dc), 32'd0);
        do_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  minuend (unsigned); captured only when start is accepted.
REQ-006 Port: b  input  WIDTH  subtrahend (unsigned); captured only when start is accepted.
REQ-007 Port: busy  output  1  high while an operation is in progress.
REQ-008 Port: done  output  1  single-cycle pulse marking a valid result.
REQ-009 Port: diff  output  WIDTH  result a - b modulo 2^WIDTH.
REQ-010 Port: borrow  output  1  final borrow; high when a < b (unsigned).
REQ-011 Port: zero  output  1  high when diff equals 0.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL, at that edge:
 - capture a and b into internal shift registers;
 - clear the borrow flop and the bit counter;
 - move to RUN.
REQ-014 Start in IDLE with start=0: stay in IDLE.
REQ-015 Each RUN edge SHALL process one bit pair, LSB first:
 - d = a0 ^ b0 ^ bin;
 - bout = (~a0 & b0) | (~(a0 ^ b0) & bin);
 - d shifts into the result register from the MSB end;
 - both operand registers shift right by one.
REQ-016 After exactly WIDTH RUN edges the FSM SHALL move to DONE; the DONE state lasts one cycle and is followed by IDLE.
REQ-017 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-018 done SHALL be 1 only in DONE.
REQ-019 Latency: for start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH+1.
REQ-020 diff, borrow and zero SHALL be valid when done=1 and SHALL hold their values until the next accepted start.
REQ-021 diff, borrow and zero are don't-care while busy=1 before done.
REQ-022 start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-023 A start in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back operations).
REQ-024 Changes on a or b after acceptance SHALL NOT affect the result in progress.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE and clear all outputs: busy=0, done=0, diff=0, borrow=0, zero=0.
REQ-026 Reset SHALL take priority over start and over any in-progress operation; the aborted result is discarded and no done pulse is produced.

Structure
REQ-027 The FSM state encoding and the default WIDTH constant SHALL live in a shared package.
REQ-028 The per-bit logic SHALL be a combinational sub-module named full_subtractor with inputs x, y, bin and outputs d, bout, instantiated once.

Verification
REQ-029 a=0x5A, b=0x3C, start pulse -> done after 10 cycles; diff=0x1E, borrow=0, zero=0.
REQ-030 a=0x00, b=0x01 -> diff=0xFF, borrow=1, zero=0.
REQ-031 a=0x77, b=0x77 -> diff=0x00, borrow=0, zero=1.
REQ-032 Start 0x10-0x01, then hold start=1 with a=0xFF, b=0x00 during RUN -> exactly one done pulse, diff=0x0F; the second request is ignored.
REQ-033 rst_n=0 at the 4th RUN edge -> next cycle busy=0, done=0, diff=0; no done pulse appears; a fresh start of 0x80-0x7F then gives diff=0x01.
REQ-034 Two back-to-back operations (0xFF-0x0F, then start in the cycle after done with 0x0F-0xFF) -> diff=0xF0 with borrow=0, then diff=0x10 with borrow=1.
